// File: rtl/uart_fifo_seq_ctrl.sv
// Sequencer for a 256x8 UART FIFO: gates host writes, pops bytes through the
// FIFO read latency and hands them to the transmitter over valid/ready.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no byte in flight; may start a pop when data is available
// S_READ  | fifo_rdb low for this single cycle
// S_WAIT  | RD_LAT cycles waiting for fifo_do; captured on the last one
// S_VALID | tx_data/tx_valid held until the transmitter takes the byte
module uart_fifo_seq_ctrl #(
    parameter int DEPTH  = 256,
    parameter int CNT_W  = 9,
    parameter int RD_LAT = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             enable,
    input  logic             wr_req,
    input  logic [7:0]       wr_data,
    output logic             overflow_err,
    input  logic             err_clr,
    output logic [7:0]       fifo_di,
    output logic             fifo_wrb,
    output logic             fifo_rdb,
    input  logic [7:0]       fifo_do,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] count
);

    localparam int LAT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] wait_cnt;
    logic [LAT_W-1:0] wait_nxt;
    logic             rdb_nxt;
    logic             txv_nxt;
    logic             tx_load;
    logic             pop;
    logic             full_i;
    logic             wr_go;

    // count already includes writes not yet visible on fifo_full
    assign full_i = fifo_full | (count == CNT_W'(DEPTH));
    assign wr_go  = wr_req & ~full_i;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        rdb_nxt   = 1'b1;
        txv_nxt   = tx_valid;
        tx_load   = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !fifo_empty && (count != '0)) begin
                    state_nxt = S_READ;
                    rdb_nxt   = 1'b0;
                    pop       = 1'b1;
                end
            end
            S_READ: begin
                state_nxt = S_WAIT;
                wait_nxt  = LAT_W'(RD_LAT - 1);
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_VALID;
                    tx_load   = 1'b1;
                    txv_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt - LAT_W'(1);
                end
            end
            S_VALID: begin
                if (tx_valid && tx_ready) begin
                    state_nxt = S_IDLE;
                    txv_nxt   = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fifo_wrb <= 1'b1;
            fifo_di  <= '0;
            fifo_rdb <= 1'b1;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            fifo_wrb <= ~wr_go;
            if (wr_go) begin
                fifo_di <= wr_data;
            end
            fifo_rdb <= rdb_nxt;
            tx_valid <= txv_nxt;
            if (tx_load) begin
                tx_data <= fifo_do;
            end
        end
    end

    // simultaneous write and pop cancel out
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= '0;
        end else begin
            case ({wr_go, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            overflow_err <= 1'b0;
        end else if (wr_req && full_i) begin
            overflow_err <= 1'b1;
        end else if (err_clr) begin
            overflow_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_seq_ctrl.sv
// Bench for uart_fifo_seq_ctrl: emulates the FIFO macro and checks every cycle
// against a byte-queue / latency model, plus directed literal expectations.
module tb_uart_fifo_seq_ctrl;

    localparam int DEPTH  = 256;
    localparam int CNT_W  = 9;
    localparam int RD_LAT = 2;

    logic             CLK;
    logic             RESET_N;
    logic             enable;
    logic             wr_req;
    logic [7:0]       wr_data;
    logic             overflow_err;
    logic             err_clr;
    logic [7:0]       fifo_di;
    logic             fifo_wrb;
    logic             fifo_rdb;
    logic [7:0]       fifo_do;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [CNT_W-1:0] count;

    uart_fifo_seq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .enable(enable), .wr_req(wr_req),
        .wr_data(wr_data), .overflow_err(overflow_err), .err_clr(err_clr),
        .fifo_di(fifo_di), .fifo_wrb(fifo_wrb), .fifo_rdb(fifo_rdb),
        .fifo_do(fifo_do), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    always @(posedge CLK) cyc++;

    // FIFO macro emulation: strobes sampled during the cycle, outputs updated
    // just after the edge, read data appears RD_LAT cycles after fifo_rdb low.
    logic [7:0] mem_q[$];
    logic [7:0] pipe [RD_LAT];
    logic       wrb_s = 1'b1;
    logic       rdb_s = 1'b1;
    logic [7:0] di_s  = 8'h00;
    int         pops_seen = 0;

    initial begin
        for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;
        fifo_do    = 8'h00;
        fifo_empty = 1'b1;
        fifo_full  = 1'b0;
    end

    always @(negedge CLK) begin
        wrb_s = fifo_wrb;
        rdb_s = fifo_rdb;
        di_s  = fifo_di;
    end

    always @(posedge CLK) begin
        #1;
        if (!RESET_N) begin
            mem_q.delete();
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (rdb_s === 1'b0) begin
                pops_seen++;
                if (mem_q.size() > 0) pipe[0] = mem_q.pop_front();
                else pipe[0] = 8'($urandom);
            end else begin
                pipe[0] = 8'($urandom);
            end
            if (wrb_s === 1'b0 && mem_q.size() < DEPTH) mem_q.push_back(di_s);
        end
        fifo_empty = (mem_q.size() == 0);
        fifo_full  = (mem_q.size() == DEPTH);
        fifo_do    = pipe[RD_LAT-1];
    end

    // Reference model: ordered byte queue, occupancy arithmetic, and pop
    // timing expressed as age (cycles since the pop) of the byte in flight.
    logic [7:0] sb_q[$];
    int         mc;
    logic       exp_wrb, exp_rdb, exp_txv, exp_ovf;
    logic [7:0] exp_di;
    bit         busy;
    int         age;
    int         dut_hs  = 0;
    int         txv_cyc = 0;

    task automatic model_reset();
        sb_q.delete();
        mc      = 0;
        exp_wrb = 1'b1;
        exp_rdb = 1'b1;
        exp_txv = 1'b0;
        exp_ovf = 1'b0;
        exp_di  = 8'h00;
        busy    = 0;
        age     = 0;
    endtask

    initial model_reset();

    always @(negedge CLK) begin
        bit full, acc, hs, pop;
        if (tx_valid === 1'b1) txv_cyc++;
        if (tx_valid === 1'b1 && tx_ready) dut_hs++;
        if (!RESET_N) begin
            model_reset();
        end else begin
            chk("fifo_wrb", 32'(fifo_wrb), 32'(exp_wrb));
            if (!exp_wrb) chk("fifo_di", 32'(fifo_di), 32'(exp_di));
            chk("fifo_rdb", 32'(fifo_rdb), 32'(exp_rdb));
            chk("tx_valid", 32'(tx_valid), 32'(exp_txv));
            if (exp_txv) begin
                if (sb_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(sb_q[0]));
                else timeout("tx_data_no_byte_expected");
            end
            chk("count", 32'(count), 32'(mc));
            chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));

            full = fifo_full || (mc == DEPTH);
            acc  = wr_req && !full;
            hs   = exp_txv && tx_ready;
            pop  = enable && !fifo_empty && (mc != 0) && !busy;
            if (hs && sb_q.size() > 0) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(wr_data);
            if (wr_req && full) exp_ovf = 1'b1;
            else if (err_clr) exp_ovf = 1'b0;
            exp_wrb = !acc;
            if (acc) exp_di = wr_data;
            mc = mc + (acc ? 1 : 0) - (pop ? 1 : 0);
            if (pop) begin
                busy = 1;
                age  = 0;
            end else begin
                if (hs) busy = 0;
                if (busy) age++;
            end
            exp_rdb = !pop;
            exp_txv = busy && (age >= RD_LAT + 1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_req  = 1'b1;
        wr_data = b;
        step(1);
        wr_req  = 1'b0;
    endtask

    task automatic wait_rdb(output int c, output bit ok);
        ok = 0;
        c  = 0;
        for (int i = 0; i < 100; i++) begin
            if (fifo_rdb === 1'b0) begin
                ok = 1;
                c  = cyc;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_txv(output int c, output bit ok);
        ok = 0;
        c  = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid === 1'b1) begin
                ok = 1;
                c  = cyc;
                break;
            end
            step(1);
        end
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok       = 0;
        enable   = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH * (RD_LAT + 3) + 200; i++) begin
            if (sb_q.size() == 0 && tx_valid === 1'b0 && count == '0) begin
                ok = 1;
                break;
            end
            step(1);
        end
        if (!ok) timeout(nm);
        step(2);
    endtask

    initial begin
        int  r_cyc, v_cyc, p0, h0, t0;
        bit  ok;
        RESET_N  = 1'b1;
        enable   = 1'b0;
        wr_req   = 1'b0;
        wr_data  = 8'h00;
        err_clr  = 1'b0;
        tx_ready = 1'b0;
        #3 RESET_N = 1'b0;
        #1;
        chk("rst_fifo_wrb", 32'(fifo_wrb), 32'd1);
        chk("rst_fifo_rdb", 32'(fifo_rdb), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        step(3);
        RESET_N = 1'b1;
        step(2);

        // single byte, end-to-end latency
        enable   = 1'b1;
        tx_ready = 1'b1;
        wr_byte(8'hA5);
        chk("single_count_after_write", 32'(count), 32'd1);
        wait_rdb(r_cyc, ok);
        if (!ok) timeout("single_rdb");
        chk("single_count_at_pop", 32'(count), 32'd0);
        step(1);
        chk("single_rdb_one_cycle", 32'(fifo_rdb), 32'd1);
        wait_txv(v_cyc, ok);
        if (!ok) timeout("single_txv");
        chk("single_latency", 32'(v_cyc - r_cyc), 32'd3);
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        step(1);
        chk("single_txv_drop", 32'(tx_valid), 32'd0);
        step(2);

        // backpressure
        enable   = 1'b0;
        tx_ready = 1'b0;
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        step(3);
        p0     = pops_seen;
        enable = 1'b1;
        step(20);
        chk("bp_one_pop", 32'(pops_seen - p0), 32'd1);
        chk("bp_count", 32'(count), 32'd2);
        chk("bp_tx_valid", 32'(tx_valid), 32'd1);
        chk("bp_tx_data", 32'(tx_data), 32'h11);
        drain("bp_drain");

        // write strobe coincides with read strobe
        enable = 1'b0;
        for (int i = 0; i < 5; i++) wr_byte(8'(8'h50 + i));
        step(3);
        chk("sim_count_before", 32'(count), 32'd5);
        enable  = 1'b1;
        wr_req  = 1'b1;
        wr_data = 8'h55;
        step(1);
        enable  = 1'b0;
        wr_req  = 1'b0;
        chk("sim_rdb_low", 32'(fifo_rdb), 32'd0);
        chk("sim_wrb_low", 32'(fifo_wrb), 32'd0);
        chk("sim_count_same", 32'(count), 32'd5);
        step(10);
        chk("sim_count_after", 32'(count), 32'd5);
        drain("sim_drain");

        // enable dropped while the pop is in flight
        enable = 1'b0;
        wr_byte(8'h61);
        wr_byte(8'h62);
        wr_byte(8'h63);
        step(3);
        p0     = pops_seen;
        h0     = dut_hs;
        enable = 1'b1;
        wait_rdb(r_cyc, ok);
        if (!ok) timeout("en_rdb");
        step(1);
        enable = 1'b0;
        step(12);
        chk("en_drop_pops", 32'(pops_seen - p0), 32'd1);
        chk("en_drop_delivered", 32'(dut_hs - h0), 32'd1);
        chk("en_drop_count", 32'(count), 32'd2);
        drain("en_drain");

        // fill to capacity, then overflow
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_req  = 1'b1;
            wr_data = 8'(i ^ 8'h3C);
            step(1);
        end
        wr_data = 8'hFF;
        chk("fill_count", 32'(count), 32'd256);
        step(1);
        wr_req = 1'b0;
        chk("ovf_no_strobe", 32'(fifo_wrb), 32'd1);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(count), 32'd256);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow_err), 32'd0);
        drain("fill_drain");

        // random interleave
        for (int i = 0; i < 3000; i++) begin
            wr_req   = ($urandom_range(0, 99) < 25);
            wr_data  = 8'($urandom);
            enable   = ($urandom_range(0, 99) < 90);
            tx_ready = ($urandom_range(0, 99) < 70);
            err_clr  = ($urandom_range(0, 99) < 3);
            step(1);
        end
        wr_req  = 1'b0;
        err_clr = 1'b0;
        drain("rand_drain");
        chk("rand_final_count", 32'(count), 32'd0);

        // reset in the middle of WAIT
        enable = 1'b0;
        wr_byte(8'h9E);
        wr_byte(8'h9F);
        step(3);
        enable   = 1'b1;
        tx_ready = 1'b1;
        wait_rdb(r_cyc, ok);
        if (!ok) timeout("rst_rdb");
        step(1);
        #2 RESET_N = 1'b0;
        #1;
        chk("rstw_fifo_wrb", 32'(fifo_wrb), 32'd1);
        chk("rstw_fifo_rdb", 32'(fifo_rdb), 32'd1);
        chk("rstw_fifo_di", 32'(fifo_di), 32'd0);
        chk("rstw_tx_data", 32'(tx_data), 32'd0);
        chk("rstw_tx_valid", 32'(tx_valid), 32'd0);
        chk("rstw_overflow", 32'(overflow_err), 32'd0);
        chk("rstw_count", 32'(count), 32'd0);
        step(2);
        RESET_N = 1'b1;
        t0 = txv_cyc;
        step(10);
        chk("rstw_no_txv_after", 32'(txv_cyc - t0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
